// File: rtl/boot_pkg.sv
// Shared types and constants for the flash boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_DONE
  } boot_state_e;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         FLASH_ADDR_W   = 24;
  localparam int         SPI_WORD_BITS  = 32;
  localparam int         CMD_BITS       = 8;

  // Flash delivers bytes b0..b3 in order; IMEM expects them little-endian.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: shifts 32-bit words full duplex, MSB first.
// A start accepted while 'ready' is high at the end of the last bit cell
// chains the next word without a gap, so chip select can stay low.
module spi_bit_engine
  import boot_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] tx_word,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        ready,
  output logic        done,
  output logic [31:0] rx_word,
  output logic [4:0]  bit_cnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(SPI_WORD_BITS - 1);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [31:0]      shift_q;
  logic             phase_end;

  assign phase_end = (div_cnt == DIV_LAST);
  assign ready     = !active || (sclk && phase_end && (bit_cnt == BIT_LAST));
  assign rx_word   = shift_q;

  // Phase counter, SCLK generation, MISO capture on rise, MOSI update on fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else begin
      done <= 1'b0;
      if (start && ready) begin
        active  <= 1'b1;
        sclk    <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
        shift_q <= tx_word;
        mosi    <= tx_word[31];
      end else if (active && ready) begin
        active  <= 1'b0;
        sclk    <= 1'b0;
        mosi    <= 1'b0;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (active) begin
        if (phase_end) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk    <= 1'b1;
            shift_q <= {shift_q[30:0], miso};
            done    <= (bit_cnt == BIT_LAST);
          end else begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            mosi    <= shift_q[31];
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Boot sequencer: reads the image from SPI flash into IMEM with one READ
// transaction, then releases the core reset.
module flash_boot_loader
  import boot_pkg::*;
#(
  parameter int                      IMEM_DEPTH = 128,
  parameter logic [FLASH_ADDR_W-1:0] FLASH_BASE = 24'h100000,
  parameter int                      CLK_DIV    = 1,
  localparam int                     AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          boot_skip,
  output logic          o_flash_sclk,
  output logic          o_flash_cs_n,
  output logic          o_flash_mosi,
  input  logic          i_flash_miso,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          boot_done,
  output logic          core_reset_n
);

  localparam logic [31:0]       CMD_WORD  = {FLASH_CMD_READ, FLASH_BASE};
  localparam logic [AW:0]       WORDS     = (AW + 1)'(IMEM_DEPTH);
  localparam int                HOLD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLK_DIV - 1);

  boot_state_e       state;
  logic              rel_q;
  logic [AW:0]       wcnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic              eng_start;
  logic [31:0]       eng_tx;
  logic              eng_ready;
  logic              eng_done;
  logic [31:0]       eng_rx;
  logic [4:0]        eng_bit_cnt;

  assign core_reset_n = boot_done;

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (eng_start),
    .tx_word (eng_tx),
    .miso    (i_flash_miso),
    .sclk    (o_flash_sclk),
    .mosi    (o_flash_mosi),
    .ready   (eng_ready),
    .done    (eng_done),
    .rx_word (eng_rx),
    .bit_cnt (eng_bit_cnt)
  );

  // Launch the command word from IDLE and chain data words back to back.
  always_comb begin
    eng_start = 1'b0;
    eng_tx    = '0;
    case (state)
      ST_IDLE: begin
        eng_start = rel_q && !boot_skip;
        eng_tx    = CMD_WORD;
      end
      ST_ADDR: eng_start = eng_ready;
      ST_DATA: eng_start = eng_ready && (wcnt != WORDS);
      default: ;
    endcase
  end

  // Boot FSM: chip select, word counting, IMEM write port and core release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      rel_q        <= 1'b0;
      o_flash_cs_n <= 1'b1;
      boot_done    <= 1'b0;
      wcnt         <= '0;
      hold_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= eng_done && ((state == ST_DATA) || (state == ST_HOLD));
      if (eng_done && ((state == ST_DATA) || (state == ST_HOLD))) begin
        imem_wdata <= byte_swap32(eng_rx);
      end
      if (imem_we) begin
        imem_addr <= imem_addr + AW'(1);
      end

      case (state)
        ST_IDLE: begin
          rel_q <= 1'b1;
          if (rel_q) begin
            if (boot_skip) begin
              state     <= ST_DONE;
              boot_done <= 1'b1;
            end else begin
              state        <= ST_CMD;
              o_flash_cs_n <= 1'b0;
            end
          end
        end
        ST_CMD: begin
          if (eng_bit_cnt == 5'(CMD_BITS)) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (eng_ready) begin
            state <= ST_DATA;
            wcnt  <= (AW + 1)'(1);
          end
        end
        ST_DATA: begin
          if (eng_ready) begin
            if (wcnt == WORDS) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end else begin
              wcnt <= wcnt + (AW + 1)'(1);
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state        <= ST_DONE;
            o_flash_cs_n <= 1'b1;
            boot_done    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: two instances (CLK_DIV=1 and CLK_DIV=3), each
// with a cycle-level mode-0 flash model and an IMEM write scoreboard.
module tb_flash_boot_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        boot_skip;
  logic [1:0]  miso;
  logic        sclk0, sclk1, cs0, cs1, mosi0, mosi1, we0, we1, bd0, bd1, cr0, cr1;
  logic [1:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;

  wire [1:0] sclk      = {sclk1, sclk0};
  wire [1:0] cs_n      = {cs1, cs0};
  wire [1:0] mosi      = {mosi1, mosi0};
  wire [1:0] we        = {we1, we0};
  wire [1:0] boot_done = {bd1, bd0};
  wire [1:0] crst      = {cr1, cr0};

  always #5 clk = ~clk;

  flash_boot_loader #(.IMEM_DEPTH(DEPTH), .FLASH_BASE(24'h100000), .CLK_DIV(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .boot_skip(boot_skip),
    .o_flash_sclk(sclk0), .o_flash_cs_n(cs0), .o_flash_mosi(mosi0), .i_flash_miso(miso[0]),
    .imem_we(we0), .imem_addr(waddr0), .imem_wdata(wdata0),
    .boot_done(bd0), .core_reset_n(cr0));

  flash_boot_loader #(.IMEM_DEPTH(DEPTH), .FLASH_BASE(24'h100000), .CLK_DIV(3)) dut1 (
    .clk(clk), .reset_n(reset_n), .boot_skip(boot_skip),
    .o_flash_sclk(sclk1), .o_flash_cs_n(cs1), .o_flash_mosi(mosi1), .i_flash_miso(miso[1]),
    .imem_we(we1), .imem_addr(waddr1), .imem_wdata(wdata1),
    .boot_done(bd1), .core_reset_n(cr1));

  typedef struct { logic [7:0] b0, b1, b2, b3; logic [31:0] word; } vec_t;
  typedef struct { logic [1:0] addr; logic [31:0] data; } exp_t;

  vec_t        tbl_a[DEPTH];
  vec_t        tbl_b[DEPTH];
  logic [7:0]  img[4*DEPTH];
  exp_t        q0[$];
  exp_t        q1[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int divs[2];
  int rise_cnt[2], low_cnt[2], high_cnt[2], cs_len[2], phase_err[2];
  int last_rises[2], last_cslen[2], fall_cyc[2], done_cyc[2], cs_falls[2], wcount[2];
  logic [31:0] cmd[2], last_cmd[2];
  logic [1:0]  prev_sclk, prev_cs, prev_we, prev_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: advance both flash models and score any IMEM write.
  task automatic tick();
    int k;
    logic bitv;
    exp_t e;
    bit have;
    logic [1:0] wa;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!cs_n[i] && prev_cs[i]) begin fall_cyc[i] = cyc; cs_falls[i]++; end
      if (cs_n[i] && !prev_cs[i]) begin
        last_rises[i] = rise_cnt[i]; last_cmd[i] = cmd[i]; last_cslen[i] = cs_len[i];
      end
      if (boot_done[i] && !prev_done[i]) done_cyc[i] = cyc;
      if (cs_n[i]) begin
        rise_cnt[i] = 0; cmd[i] = '0; low_cnt[i] = 0; high_cnt[i] = 0; cs_len[i] = 0;
      end else begin
        cs_len[i]++;
        if (sclk[i] && !prev_sclk[i]) begin
          if (low_cnt[i] != divs[i]) phase_err[i]++;
          if (rise_cnt[i] < 32) cmd[i] = {cmd[i][30:0], mosi[i]};
          rise_cnt[i]++; low_cnt[i] = 0; high_cnt[i] = 1;
        end else if (!sclk[i] && prev_sclk[i]) begin
          if (high_cnt[i] != divs[i]) phase_err[i]++;
          high_cnt[i] = 0; low_cnt[i] = 1;
        end else if (sclk[i]) begin
          high_cnt[i]++;
        end else begin
          low_cnt[i]++;
        end
      end
      k = rise_cnt[i] - 32;
      bitv = 1'b1;
      if (!cs_n[i] && k >= 0 && k < 32*DEPTH) bitv = img[k/8][7-(k%8)];
      miso[i] = (i == 1 && low_cnt[i] != divs[i]) ? ~bitv : bitv;
      if (we[i]) begin
        wcount[i]++;
        wa = (i == 0) ? waddr0 : waddr1;
        wd = (i == 0) ? wdata0 : wdata1;
        chk($sformatf("we_width_%0d", i), 64'(prev_we[i]), 64'd0);
        have = 1'b0;
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write_%0d: got addr %0d data 0x%08h, expected no write", i, wa, wd);
        end else begin
          chk($sformatf("waddr_%0d", i), 64'(wa), 64'(e.addr));
          chk($sformatf("wdata_%0d", i), 64'(wd), 64'(e.data));
        end
      end
    end
    prev_sclk = sclk; prev_cs = cs_n; prev_we = we; prev_done = boot_done;
  endtask

  task automatic push_tbl(input int set);
    vec_t v;
    exp_t e;
    for (int j = 0; j < DEPTH; j++) begin
      v = (set == 0) ? tbl_a[j] : tbl_b[j];
      img[4*j] = v.b0; img[4*j+1] = v.b1; img[4*j+2] = v.b2; img[4*j+3] = v.b3;
      e.addr = 2'(j);
      e.data = v.word;
      q0.push_back(e);
      q1.push_back(e);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cs_n"}, 64'(cs_n), 64'd3);
    chk({tag, "_sclk"}, 64'(sclk), 64'd0);
    chk({tag, "_mosi"}, 64'(mosi), 64'd0);
    chk({tag, "_we"}, 64'(we), 64'd0);
    chk({tag, "_addr"}, 64'({waddr1, waddr0}), 64'd0);
    chk({tag, "_wdata"}, {wdata1, wdata0}, 64'd0);
    chk({tag, "_boot_done"}, 64'(boot_done), 64'd0);
    chk({tag, "_core_reset_n"}, 64'(crst), 64'd0);
  endtask

  task automatic run_check(input string tag);
    int n;
    int exp_len;
    n = 0;
    while (boot_done !== 2'b11 && n < 5000) begin tick(); n++; end
    chk({tag, "_done_timeout"}, 64'(n < 5000), 64'd1);
    for (int i = 0; i < 2; i++) begin
      exp_len = 2*divs[i]*(32 + 32*DEPTH) + divs[i];
      chk($sformatf("%s_done_latency_%0d", tag, i), 64'(done_cyc[i] - fall_cyc[i]), 64'(exp_len));
      chk($sformatf("%s_cs_low_len_%0d", tag, i), 64'(last_cslen[i]), 64'(exp_len));
      chk($sformatf("%s_rises_%0d", tag, i), 64'(last_rises[i]), 64'(32 + 32*DEPTH));
      chk($sformatf("%s_cmd_addr_%0d", tag, i), 64'(last_cmd[i]), 64'h03100000);
      chk($sformatf("%s_phase_err_%0d", tag, i), 64'(phase_err[i]), 64'd0);
    end
    chk({tag, "_pending_0"}, 64'(q0.size()), 64'd0);
    chk({tag, "_pending_1"}, 64'(q1.size()), 64'd0);
    chk({tag, "_core_reset_n"}, 64'(crst), 64'd3);
  endtask

  initial begin
    int n, viol, base0, base1, cf0, cf1;
    divs[0] = 1; divs[1] = 3;
    for (int i = 0; i < 2; i++) begin
      rise_cnt[i] = 0; low_cnt[i] = 0; high_cnt[i] = 0; cs_len[i] = 0; phase_err[i] = 0;
      last_rises[i] = 0; last_cslen[i] = 0; fall_cyc[i] = 0; done_cyc[i] = 0;
      cs_falls[i] = 0; wcount[i] = 0; cmd[i] = '0; last_cmd[i] = '0;
    end
    prev_sclk = 2'b00; prev_cs = 2'b11; prev_we = 2'b00; prev_done = 2'b00;
    tbl_a[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 32'h00000013};
    tbl_a[1] = '{8'hEF, 8'h00, 8'h80, 8'h00, 32'h008000EF};
    tbl_a[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
    tbl_a[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    tbl_b[0] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};
    tbl_b[1] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h01000080};
    tbl_b[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    tbl_b[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};
    for (int j = 0; j < 4*DEPTH; j++) img[j] = 8'h00;

    reset_n = 1'b0; boot_skip = 1'b0; miso = 2'b00;
    repeat (3) tick();
    check_reset("rst0");

    // full load, then the first two edges after release
    push_tbl(0);
    reset_n = 1'b1;
    tick();
    chk("edge1_cs_n", 64'(cs_n), 64'd3);
    tick();
    chk("edge2_cs_n", 64'(cs_n), 64'd0);
    run_check("run1");

    // DONE is absorbing
    base0 = wcount[0]; base1 = wcount[1]; viol = 0;
    repeat (1000) begin
      tick();
      if (cs_n !== 2'b11 || sclk !== 2'b00 || mosi !== 2'b00 || boot_done !== 2'b11) viol++;
    end
    chk("post_done_idle_viol", 64'(viol), 64'd0);
    chk("post_done_writes", 64'((wcount[0] - base0) + (wcount[1] - base1)), 64'd0);

    // reset pulse after the second write, then a full rerun
    reset_n = 1'b0;
    repeat (2) tick();
    push_tbl(1);
    base0 = wcount[0];
    reset_n = 1'b1;
    n = 0;
    while (wcount[0] < base0 + 2 && n < 2000) begin tick(); n++; end
    chk("wait_2nd_write_timeout", 64'(n < 2000), 64'd1);
    tick();
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    chk("pending_after_abort", 64'(q0.size()), 64'd2);
    q0.delete();
    q1.delete();
    repeat (2) tick();
    push_tbl(1);
    reset_n = 1'b1;
    run_check("rerun");

    // boot_skip at release
    reset_n = 1'b0; boot_skip = 1'b1;
    repeat (2) tick();
    base0 = wcount[0]; base1 = wcount[1]; cf0 = cs_falls[0]; cf1 = cs_falls[1];
    reset_n = 1'b1;
    tick();
    chk("skip_edge1_boot_done", 64'(boot_done), 64'd0);
    tick();
    chk("skip_edge2_boot_done", 64'(boot_done), 64'd3);
    chk("skip_edge2_core_reset_n", 64'(crst), 64'd3);
    repeat (50) tick();
    chk("skip_cs_falls", 64'((cs_falls[0] - cf0) + (cs_falls[1] - cf1)), 64'd0);
    chk("skip_writes", 64'((wcount[0] - base0) + (wcount[1] - base1)), 64'd0);
    chk("skip_cs_n", 64'(cs_n), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Boot sequencer between the on-board SPI configuration flash and the SoC instruction memory. After reset it issues one continuous SPI READ (0x03) transaction, shifts in `IMEM_DEPTH` 32-bit words and writes them into IMEM through a simple write port. It holds the core in reset until the image is loaded and then releases it. It sits in the FPGA top level, drives the flash pins (`o_flash_sclk` goes to STARTUPE2 USRCCLKO) and gates the reset to `rv32i_soc`.

## Interface
Parameters:
- `IMEM_DEPTH`, 128: number of 32-bit words loaded; IMEM word address width `AW = $clog2(IMEM_DEPTH)`.
- `FLASH_BASE`, 24'h100000: flash byte address of the first image byte.
- `CLK_DIV`, 1: `clk` cycles per SCLK half-period; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `boot_skip`  in  1  when 1 at reset release, no flash access is made and the core is released immediately.
- `o_flash_sclk`  out  1  SPI clock, mode 0, idles low.
- `o_flash_cs_n`  out  1  flash chip select, active low.
- `o_flash_mosi`  out  1  master out.
- `i_flash_miso`  in  1  master in.
- `imem_we`  out  1  one-cycle IMEM write strobe.
- `imem_addr`  out  AW  IMEM word address.
- `imem_wdata`  out  32  IMEM write data.
- `boot_done`  out  1  image loaded or skipped; sticky until reset.
- `core_reset_n`  out  1  active-low reset for the core; equals `boot_done`.

## Operation
- Reset values:
  - `o_flash_cs_n`=1; `o_flash_sclk`=0; `o_flash_mosi`=0.
  - `imem_we`=0; `imem_addr`=0; `imem_wdata`=0.
  - `boot_done`=0; `core_reset_n`=0.
- FSM states: IDLE → CMD → ADDR → DATA → HOLD → DONE.
- IDLE is one cycle after reset release. It samples `boot_skip`: 1 → DONE, 0 → CMD.
- CMD shifts 8 bits of 0x03. ADDR shifts the 24 bits of `FLASH_BASE`. Both are MSB first on MOSI. MISO is ignored during CMD and ADDR.
- DATA shifts `32*IMEM_DEPTH` bits. Each byte arrives MSB first.
- Word assembly is little-endian: flash bytes b0,b1,b2,b3 form `{b3,b2,b1,b0}`.
- After each 32nd data bit is sampled, `imem_we` pulses for one cycle with the assembled word on `imem_wdata`. `imem_addr` starts at 0 and increments after each write.
- HOLD: SCLK stays low and `cs_n` stays low for `CLK_DIV` cycles. On exit, `cs_n` goes to 1 and the FSM moves to DONE.
- DONE is absorbing. `boot_done` and `core_reset_n` are 1, all flash outputs are at idle values, and no further writes occur.
- Flash addresses are 24 bits. No range check is made; address wrap inside the flash is the flash's behaviour.

## Timing
- Bit cell is 2·`CLK_DIV` cycles: SCLK low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles.
- MOSI changes only at the start of the low phase.
- MISO is registered on the `clk` edge where SCLK goes 0→1.
- `cs_n` falls on the IDLE→CMD edge, together with MOSI = first command bit and the start of the first low phase.
- `imem_we` is asserted on the edge following the sample of a word's last bit. The write for the final word occurs during HOLD.
- The cycle count from `cs_n` fall to `cs_n` rise is exactly 2·`CLK_DIV`·(32+32·`IMEM_DEPTH`)+`CLK_DIV`. `boot_done` and `core_reset_n` rise on the same edge as `cs_n`.
- With `boot_skip`, `boot_done` rises on the second `clk` edge after reset release; `cs_n` never falls.
- Reset asserted mid-operation forces all outputs to reset values asynchronously, including `cs_n`=1, which aborts the flash read. After release the sequence restarts from CMD at `imem_addr`=0.

## Structure
- `boot_pkg` holds:
  - the state enum `boot_state_e`;
  - `FLASH_CMD_READ = 8'h03`;
  - `FLASH_ADDR_W = 24`.
- Sub-module `spi_bit_engine` generates the SCLK phases and full-duplex bit shifting. It has a `start` input, a 32-bit shift register, a `bit_cnt` target and a `done` output. It is reused for the CMD+ADDR phase (32 bits) and for each DATA word (32 bits) without deasserting `cs_n`.
- The top FSM owns `cs_n`, the IMEM port and the release logic.

## Test plan
Bench settings: `CLK_DIV`=1, `IMEM_DEPTH`=4, `FLASH_BASE`=24'h100000, with a mode-0 flash model.
- Command/address capture: bits sampled on SCLK rises read 0x03, 0x10, 0x00, 0x00. `cs_n` is low continuously, and there are exactly 32+128 SCLK rises.
- Data load: model returns 13 00 00 00, EF 00 80 00, 01 02 03 04, FF FF FF FF → writes `addr0`=0x00000013, `addr1`=0x008000EF, `addr2`=0x04030201, `addr3`=0xFFFFFFFF. Each `imem_we` is one cycle wide. `boot_done` rises 321 cycles after `cs_n` falls.
- `boot_skip`=1 at release → `core_reset_n`=1 on the 2nd edge, zero `imem_we` pulses, `cs_n` stays 1.
- Reset pulse after the 2nd write → outputs return to reset values immediately. After release a full sequence reruns from `addr0`, giving 4 writes with correct data.
- `CLK_DIV`=3: SCLK high and low phases are 3 cycles each. The model drives a wrong MISO value except in the cycle before each rise; data must still load correctly.
- After DONE: over 1000 further cycles there are no `imem_we` pulses, `cs_n`=1, SCLK=0, and `boot_done` stays 1.
